// File: rtl/output_bram_drain_pkg.sv
// Shared types and constants for the output BRAM drain engine.
package output_bram_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int RD_LAT_1DCONV    = 2;
  localparam int RD_LAT_TRANSCONV = 1;

  localparam logic CONV_1D    = 1'b0;
  localparam logic CONV_TRANS = 1'b1;

endpackage

// File: rtl/output_bram_drain_if.sv
// AXI-Stream link from the drain engine toward the DMA/host path.
// Valid/ready: a beat transfers on a cycle where tvalid && tready; once tvalid
// rises, tdata and tlast hold until that handshake.
interface output_bram_drain_if #(
  parameter int DW = 16
) ();
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/output_bram_drain_row_serializer.sv
// Two-slot ping-pong row buffer; emits the read slot lane by lane on AXIS.
module row_serializer #(
  parameter int DW        = 16,
  parameter int NUM_BRAMS = 16,
  parameter int ROWW      = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    cap_i,
  input  logic [NUM_BRAMS*DW-1:0] cap_data_i,
  input  logic [ROWW-1:0]         num_rows_i,
  output logic [1:0]              full_o,
  output_bram_drain_if.master     axis
);

  localparam int LW = $clog2(NUM_BRAMS);

  logic [NUM_BRAMS*DW-1:0] slot_q [2];
  logic [1:0]              full_q, full_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           lane_q, lane_d;
  logic [ROWW-1:0]         row_q, row_d;
  logic                    last_lane, hs;

  assign last_lane   = (lane_q == LW'(NUM_BRAMS - 1));
  assign axis.tvalid = full_q[rd_ptr_q];
  assign axis.tdata  = slot_q[rd_ptr_q][lane_q*DW +: DW];
  assign axis.tlast  = axis.tvalid && last_lane && (row_q == num_rows_i - ROWW'(1));
  assign hs          = axis.tvalid && axis.tready;
  assign full_o      = full_q;

  // Capture only ever targets an empty slot, so free-then-set ordering is safe.
  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    row_d    = row_q;
    if (hs) begin
      lane_d = lane_q + LW'(1);
      if (last_lane) begin
        lane_d           = '0;
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
        row_d            = row_q + ROWW'(1);
      end
    end
    if (cap_i) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      lane_q   <= '0;
      row_q    <= '0;
    end else begin
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      row_q    <= row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) slot_q[s] <= '0;
    end else if (cap_i) begin
      slot_q[wr_ptr_q] <= cap_data_i;
    end
  end

endmodule

// File: rtl/output_bram_drain.sv
// Drain engine: owns the output BRAM bank read port while busy and streams rows out.
// Optional build macro OUTPUT_DRAIN_PERF_EN adds the stall_cycles counter output.
module output_bram_drain
  import output_bram_drain_pkg::*;
#(
  parameter int DW         = 16,
  parameter int NUM_BRAMS  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            conv_mode,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_rows,
  output logic                            ext_read_mode,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
  output logic [NUM_BRAMS-1:0]            ext_enb,
  input  logic [NUM_BRAMS*DW-1:0]         rd_data_flat,
  output_bram_drain_if.master             m_axis,
`ifdef OUTPUT_DRAIN_PERF_EN
  output logic [31:0]                     stall_cycles,
`endif
  output logic                            busy,
  output logic                            done
);

  state_e                     state_q, state_d;
  logic                       mode_q;
  logic [ADDR_WIDTH-1:0]      base_q;
  logic [ADDR_WIDTH:0]        rows_q;
  logic [ADDR_WIDTH:0]        row_idx_q;
  logic [1:0]                 inflight_q;
  logic [RD_LAT_1DCONV-1:0]   dl_q;
  logic [1:0]                 full;
  logic [1:0]                 free_slots;
  logic                       start_acc, issue, last_issue, arrive, last_hs;
  logic [ADDR_WIDTH-1:0]      rd_addr;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign free_slots = 2'd2 - {1'b0, full[0]} - {1'b0, full[1]};
  // Reads in flight count against free slots so the buffer can never be overrun.
  assign issue      = (state_q == ST_ISSUE) && (free_slots > inflight_q);
  assign last_issue = issue && (row_idx_q == rows_q - (ADDR_WIDTH+1)'(1));
  assign arrive     = (mode_q == CONV_TRANS) ? dl_q[RD_LAT_TRANSCONV-1] : dl_q[RD_LAT_1DCONV-1];
  assign last_hs    = m_axis.tvalid && m_axis.tready && m_axis.tlast;
  assign rd_addr    = base_q + row_idx_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_rows == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (last_issue) state_d = ST_WAIT;
      ST_WAIT:  if (last_hs) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ext_read_mode      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    busy               = (state_q != ST_IDLE);
    done               = (state_q == ST_DONE);
    ext_enb            = {NUM_BRAMS{issue}};
    ext_read_addr_flat = {NUM_BRAMS{rd_addr}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= CONV_1D;
      base_q     <= '0;
      rows_q     <= '0;
      row_idx_q  <= '0;
      inflight_q <= '0;
      dl_q       <= '0;
    end else if (start_acc) begin
      mode_q     <= conv_mode;
      base_q     <= base_addr;
      rows_q     <= num_rows;
      row_idx_q  <= '0;
      inflight_q <= '0;
      dl_q       <= '0;
    end else begin
      row_idx_q  <= row_idx_q + (ADDR_WIDTH+1)'(issue);
      inflight_q <= inflight_q + {1'b0, issue} - {1'b0, arrive};
      dl_q       <= {dl_q[RD_LAT_1DCONV-2:0], issue};
    end
  end

  row_serializer #(
    .DW        (DW),
    .NUM_BRAMS (NUM_BRAMS),
    .ROWW      (ADDR_WIDTH + 1)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (start_acc),
    .cap_i      (arrive),
    .cap_data_i (rd_data_flat),
    .num_rows_i (rows_q),
    .full_o     (full),
    .axis       (m_axis)
  );

`ifdef OUTPUT_DRAIN_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n || start_acc)                                     stall_q <= '0;
    else if (m_axis.tvalid && !m_axis.tready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_output_bram_drain.sv
// Directed bench for output_bram_drain with a bank model and an expected-beat queue.
module tb_output_bram_drain;

  localparam int DW = 16;
  localparam int NB = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic conv_mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_rows = '0;
  logic ext_read_mode;
  logic [NB*AW-1:0] addr_flat;
  logic [NB-1:0] ext_enb;
  logic [NB*DW-1:0] rd_data_flat = '0;
  logic busy, done;
`ifdef OUTPUT_DRAIN_PERF_EN
  logic [31:0] stall_cycles;
`endif

  output_bram_drain_if #(.DW(DW)) m_axis ();

  output_bram_drain #(.DW(DW), .NUM_BRAMS(NB), .ADDR_WIDTH(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .conv_mode          (conv_mode),
    .base_addr          (base_addr),
    .num_rows           (num_rows),
    .ext_read_mode      (ext_read_mode),
    .ext_read_addr_flat (addr_flat),
    .ext_enb            (ext_enb),
    .rd_data_flat       (rd_data_flat),
    .m_axis             (m_axis),
`ifdef OUTPUT_DRAIN_PERF_EN
    .stall_cycles       (stall_cycles),
`endif
    .busy               (busy),
    .done               (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bank model: lane i of address a holds a*16+i
  int cur_lat = 1;
  logic [NB*DW-1:0] stage1 = '0;

  function automatic logic [NB*DW-1:0] row_word(input logic [AW-1:0] a);
    logic [NB*DW-1:0] w;
    for (int i = 0; i < NB; i++) w[i*DW +: DW] = DW'(int'(a) * 16 + i);
    return w;
  endfunction

  always @(posedge clk) begin
    if (ext_enb[0]) stage1 <= row_word(addr_flat[AW-1:0]);
    if (cur_lat == 1) begin
      if (ext_enb[0]) rd_data_flat <= row_word(addr_flat[AW-1:0]);
    end else begin
      rd_data_flat <= stage1;
    end
  end

  // scoreboard state
  int n_assert = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];
  int exp_base, exp_rows, iss_cnt, beat_cnt, drained, cyc;
  int first_tv_n, last_hs_n, done_n, done_cnt, gap_cnt, stall_cnt;
  bit seen_tv, prev_stall, mon_en, rand_ready;
  logic [DW-1:0] prev_data, popped;
  logic prev_last;
  logic [AW-1:0] exp_addr;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ready driver
  initial begin
    m_axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pushes expected beats on each issued read, pops on each handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else if (mon_en) begin
      cyc++;
      if (ext_enb != '0) begin
        chk("enb_all_lanes", ext_enb, {NB{1'b1}});
        exp_addr = AW'(exp_base + iss_cnt);
        chk("rd_addr", addr_flat, {NB{exp_addr}});
        for (int i = 0; i < NB; i++) exp_q.push_back(DW'(int'(exp_addr) * 16 + i));
        iss_cnt++;
        chk("occupancy_le2", (iss_cnt - drained) <= 2, 1);
      end
      if (m_axis.tvalid) begin
        if (!seen_tv) first_tv_n = cyc;
        seen_tv = 1'b1;
      end else if (seen_tv && beat_cnt < exp_rows * 16) begin
        gap_cnt++;
      end
      if (prev_stall) begin
        chk("stable_tdata", m_axis.tdata, prev_data);
        chk("stable_tlast", m_axis.tlast, prev_last);
      end
      if (m_axis.tvalid && !m_axis.tready) stall_cnt++;
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          popped = exp_q.pop_front();
          chk("tdata", m_axis.tdata, popped);
        end
        chk("tlast", m_axis.tlast, beat_cnt == exp_rows * 16 - 1);
        if (m_axis.tlast) last_hs_n = cyc;
        beat_cnt++;
        if (beat_cnt % 16 == 0) drained++;
      end
      prev_stall = m_axis.tvalid && !m_axis.tready;
      prev_data  = m_axis.tdata;
      prev_last  = m_axis.tlast;
      if (done) begin
        done_cnt++;
        done_n = cyc;
        chk("read_mode_off_in_done", ext_read_mode, 0);
      end
    end
  end

  task automatic clear_sb(input int base, input int rows, input int lat, input bit rnd);
    cur_lat = lat; exp_base = base; exp_rows = rows; rand_ready = rnd;
    iss_cnt = 0; beat_cnt = 0; drained = 0; cyc = 0; first_tv_n = -1; last_hs_n = -1;
    done_n = -1; done_cnt = 0; gap_cnt = 0; stall_cnt = 0; seen_tv = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic mode, input int base, input int rows);
    start = 1'b1; conv_mode = mode; base_addr = AW'(base); num_rows = (AW+1)'(rows);
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    start = 1'b0; conv_mode = ~mode; base_addr = ~AW'(base); num_rows = (AW+1)'(5);
  endtask

  task automatic run_xfer(input logic mode, input int base, input int rows, input bit rnd,
                          input bit busy_start);
    @(negedge clk);
    clear_sb(base, rows, mode ? 1 : 2, rnd);
    mon_en = 1'b1;
    pulse_start(mode, base, rows);
    if (busy_start) begin
      repeat (4) @(negedge clk);
      start = 1'b1; num_rows = '0;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk);
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("beats", beat_cnt, rows * 16);
    chk("reads_issued", iss_cnt, rows);
    chk("sb_empty", exp_q.size(), 0);
    chk("idle_after", busy, 0);
    if (rows > 0) begin
      chk("first_tvalid_cycles", first_tv_n, (mode ? 1 : 2) + 2);
      chk("done_after_last_hs", done_n, last_hs_n + 1);
      if (!rnd) chk("no_gaps", gap_cnt, 0);
    end else begin
      chk("done_latency", done_n, 1);
      chk("no_tvalid", seen_tv, 0);
    end
`ifdef OUTPUT_DRAIN_PERF_EN
    chk("stall_cycles", stall_cycles, stall_cnt);
`endif
    rand_ready = 1'b0;
  endtask

  initial begin
    mon_en = 1'b0;
    rand_ready = 1'b0;
    clear_sb(0, 0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ext_read_mode, ext_enb, addr_flat, m_axis.tvalid, m_axis.tdata,
                          m_axis.tlast, busy, done}, '0);
    rst_n = 1'b1;

    run_xfer(1'b1, 0, 2, 1'b0, 1'b0);     // TRANSCONV, 32 beats
    run_xfer(1'b0, 0, 3, 1'b0, 1'b1);     // 1DCONV, start while busy ignored
    run_xfer(1'b0, 100, 10, 1'b1, 1'b0);  // random backpressure
    run_xfer(1'b1, 1022, 4, 1'b0, 1'b0);  // address wrap
    run_xfer(1'b1, 1020, 8, 1'b0, 1'b0);  // address wrap, longer
    run_xfer(1'b1, 0, 0, 1'b0, 1'b0);     // zero rows

    // abort mid-row: reset while beat 7 of row 1 is presented
    @(negedge clk);
    clear_sb(0, 3, 1, 0);
    mon_en = 1'b1;
    pulse_start(1'b1, 0, 3);
    for (int k = 0; k < 200 && beat_cnt < 23; k++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_point_reached", beat_cnt, 23);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs_zero", {ext_read_mode, ext_enb, addr_flat, m_axis.tvalid, m_axis.tdata,
                               m_axis.tlast, busy, done}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_done_on_abort", done_cnt, 0);
    run_xfer(1'b1, 5, 2, 1'b0, 1'b0);     // clean drain after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
